// File: rtl/gol_display_engine.sv
// Game-of-Life display pixel pipeline: beam position -> cell address -> colour index -> palette RGB.
// Three registered stages; memory is synchronous, so pixel_in belongs to the pixel two edges back.
module gol_display_engine #(
    parameter int         CELL_SHIFT = 3,
    parameter int         COL_BITS   = 6,
    parameter int         ROWS       = 48,
    parameter int         PPW_BITS   = 3,
    parameter int         ADDR_W     = 9,
    parameter logic [3:0] BORDER_IDX = 4'h1
) (
    input  logic                clk_25,
    input  logic                rst_n,
    input  logic [9:0]          video_x,
    input  logic [9:0]          video_y,
    input  logic                display_enable,
    input  logic                frame_end,
    input  logic [1:0]          mode,
    input  logic [3:0]          solid_idx,
    input  logic                swap_req,
    input  logic                pal_we,
    input  logic [3:0]          pal_addr,
    input  logic [23:0]         pal_data,
    input  logic [3:0]          pixel_in,
    output logic                bank,
    output logic [ADDR_W-1:0]   addr,
    output logic [PPW_BITS-1:0] pix_sel,
    output logic                swap_done,
    output logic [7:0]          frame_cnt,
    output logic [7:0]          r,
    output logic [7:0]          g,
    output logic [7:0]          b
);

    localparam int LIN_W = 10 + COL_BITS;

    // ---------------- stage 0: cell mapping ----------------
    logic [9:0]       w_cx;
    logic [9:0]       w_cy;
    logic             w_in_grid;
    logic [LIN_W-1:0] w_lin;

    assign w_cx      = video_x >> CELL_SHIFT;
    assign w_cy      = video_y >> CELL_SHIFT;
    assign w_in_grid = (w_cx < 10'(1 << COL_BITS)) && (w_cy < 10'(ROWS));
    // Row-major index by concatenation; grid width is a power of two.
    assign w_lin     = {w_cy, w_cx[COL_BITS-1:0]};

    logic       r_mode_q;
    logic [1:0] r_mode;
    logic       r_swap_pend;

    logic [3:0] r_s1_cx, r_s2_cx;
    logic       r_s1_cy0, r_s2_cy0;
    logic       r_s1_grid, r_s2_grid;
    logic       r_s1_de, r_s2_de;
    logic [1:0] r_s1_mode, r_s2_mode;
    logic [1:0] r_vld_pipe;

    assign r_mode_q = 1'b0;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            pix_sel    <= '0;
            r_s1_cx    <= '0;
            r_s1_cy0   <= 1'b0;
            r_s1_grid  <= 1'b0;
            r_s1_de    <= 1'b0;
            r_s1_mode  <= '0;
            r_s2_cx    <= '0;
            r_s2_cy0   <= 1'b0;
            r_s2_grid  <= 1'b0;
            r_s2_de    <= 1'b0;
            r_s2_mode  <= '0;
            r_vld_pipe <= '0;
        end else begin
            addr       <= ADDR_W'(w_lin >> PPW_BITS);
            pix_sel    <= w_lin[PPW_BITS-1:0];
            // Mode travels with the pixel so a frame_end switch never splits a pixel.
            r_s1_cx    <= w_cx[3:0];
            r_s1_cy0   <= w_cy[0];
            r_s1_grid  <= w_in_grid;
            r_s1_de    <= display_enable;
            r_s1_mode  <= r_mode;
            r_s2_cx    <= r_s1_cx;
            r_s2_cy0   <= r_s1_cy0;
            r_s2_grid  <= r_s1_grid;
            r_s2_de    <= r_s1_de;
            r_s2_mode  <= r_s1_mode;
            r_vld_pipe <= {r_vld_pipe[0], 1'b1};
        end
    end

    // ---------------- frame-level control ----------------
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= '0;
            frame_cnt   <= '0;
            bank        <= 1'b0;
            r_swap_pend <= 1'b0;
            swap_done   <= 1'b0;
        end else begin
            if (frame_end) begin
                r_mode    <= mode;
                frame_cnt <= frame_cnt + 8'd1;
            end
            // A request coinciding with frame_end flips immediately; extras collapse into one.
            if (frame_end && (r_swap_pend || swap_req)) begin
                bank        <= ~bank;
                r_swap_pend <= 1'b0;
                swap_done   <= 1'b1;
            end else begin
                swap_done <= 1'b0;
                if (swap_req) r_swap_pend <= 1'b1;
            end
        end
    end

    // ---------------- palette ----------------
    logic [23:0] r_pal [16];

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) r_pal[i] <= {3{8'(i * 17)}};
        end else if (pal_we) begin
            r_pal[pal_addr] <= pal_data;
        end
    end

    // ---------------- stage 2: index select and lookup ----------------
    logic [3:0]  w_idx;
    logic [23:0] w_rgb;

    always_comb begin
        w_idx = BORDER_IDX;
        if (r_s2_grid) begin
            unique case (r_s2_mode)
                2'd0:    w_idx = pixel_in;
                2'd1:    w_idx = frame_cnt[3:0] + r_s2_cx;
                2'd2:    w_idx = (r_s2_cx[0] ^ r_s2_cy0) ? 4'hF : 4'h0;
                default: w_idx = solid_idx;
            endcase
        end
    end

    assign w_rgb = r_pal[w_idx];

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else if (r_vld_pipe[1] && r_s2_de) begin
            r <= w_rgb[23:16];
            g <= w_rgb[15:8];
            b <= w_rgb[7:0];
        end else begin
            r <= '0;
            g <= '0;
            b <= '0;
        end
    end

endmodule

// File: tb/tb_gol_display_engine.sv
// Randomised and directed checks of gol_display_engine against a cycle-history reference model.
module tb_gol_display_engine;

    logic        clk_25 = 1'b0;
    logic        rst_n;
    logic [9:0]  video_x, video_y;
    logic        display_enable, frame_end, swap_req, pal_we;
    logic [1:0]  mode;
    logic [3:0]  solid_idx, pal_addr, pixel_in;
    logic [23:0] pal_data;
    logic        bank, swap_done;
    logic [8:0]  addr;
    logic [2:0]  pix_sel;
    logic [7:0]  frame_cnt, r, g, b;

    always #5 clk_25 = ~clk_25;

    gol_display_engine dut (
        .clk_25(clk_25), .rst_n(rst_n), .video_x(video_x), .video_y(video_y),
        .display_enable(display_enable), .frame_end(frame_end), .mode(mode),
        .solid_idx(solid_idx), .swap_req(swap_req), .pal_we(pal_we),
        .pal_addr(pal_addr), .pal_data(pal_data), .pixel_in(pixel_in),
        .bank(bank), .addr(addr), .pix_sel(pix_sel), .swap_done(swap_done),
        .frame_cnt(frame_cnt), .r(r), .g(g), .b(b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [23:0] m_pal [16];
    int          m_mode, m_fc, m_edges;
    bit          m_bank, m_pend, m_sd;
    int          h_x [4], h_y [4], h_mode [4];
    bit          h_de [4];
    logic [23:0] exp_rgb;
    int          exp_addr, exp_sel;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_pal[i] = {3{8'(i * 17)}};
        m_mode = 0; m_fc = 0; m_edges = 0;
        m_bank = 0; m_pend = 0; m_sd = 0;
        exp_rgb = 0; exp_addr = 0; exp_sel = 0;
    endtask

    function automatic logic [23:0] colour(int x, int y, int md, bit de, int pin, int sidx);
        int cx, cy, idx;
        if (!de) return 24'h0;
        cx = x / 8;
        cy = y / 8;
        if (cx >= 64 || cy >= 48) idx = 1;
        else case (md)
            0:       idx = pin;
            1:       idx = (m_fc + cx) % 16;
            2:       idx = ((cx + cy) % 2 == 1) ? 15 : 0;
            default: idx = sidx;
        endcase
        return m_pal[idx];
    endfunction

    // Advance one clock: the model consumes the inputs present at the edge, then outputs settle.
    task automatic tick();
        int slot, old, lin;
        @(posedge clk_25);
        m_edges++;
        slot = m_edges % 4;
        h_x[slot] = video_x; h_y[slot] = video_y;
        h_de[slot] = display_enable; h_mode[slot] = m_mode;
        if (m_edges >= 3) begin
            old = (m_edges - 2) % 4;
            exp_rgb = colour(h_x[old], h_y[old], h_mode[old], h_de[old], pixel_in, solid_idx);
        end else exp_rgb = 24'h0;
        lin = (video_y / 8) * 64 + (video_x / 8) % 64;
        exp_addr = (lin / 8) % 512;
        exp_sel = lin % 8;
        if (pal_we) m_pal[pal_addr] = pal_data;
        if (frame_end) begin
            m_mode = mode;
            m_fc = (m_fc + 1) % 256;
        end
        if (frame_end && (m_pend || swap_req)) begin
            m_bank = !m_bank; m_pend = 0; m_sd = 1;
        end else begin
            m_sd = 0;
            if (swap_req) m_pend = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        video_x = 10'd24; video_y = 10'd8; display_enable = 1'b1;
        repeat (2) @(posedge clk_25);
        #1;
        n_vec++;
        if ({r, g, b, addr, pix_sel, bank, swap_done, frame_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_state got rgb=%h addr=%0d sel=%0d bank=%b sd=%b fc=%0d want all 0",
                     {r, g, b}, addr, pix_sel, bank, swap_done, frame_cnt);
        end
        rst_n = 1'b1;
        m_reset();
        for (int i = 0; i < 6; i++) begin
            video_x = 10'($urandom_range(0, 511));
            video_y = 10'($urandom_range(0, 383));
            pixel_in = 4'($urandom_range(1, 15));
            tick();
            n_vec++;
            if (i < 2 && {r, g, b} !== 24'h0) begin
                n_err++;
                $display("FAIL reset_black cyc %0d got %h want 000000", i, {r, g, b});
            end
            n_vec++;
            if ({r, g, b} !== exp_rgb || addr !== 9'(exp_addr) || pix_sel !== 3'(exp_sel)) begin
                n_err++;
                $display("FAIL reset_release cyc %0d got rgb=%h addr=%0d sel=%0d want rgb=%h addr=%0d sel=%0d",
                         i, {r, g, b}, addr, pix_sel, exp_rgb, exp_addr, exp_sel);
            end
        end
    endtask

    task automatic test_addr_map();
        video_x = 10'd24; video_y = 10'd8; pixel_in = 4'h5; display_enable = 1'b1;
        tick();
        n_vec++;
        if (addr !== 9'd8 || pix_sel !== 3'd3) begin
            n_err++;
            $display("FAIL addr_24_8 got addr=%0d sel=%0d want addr=8 sel=3", addr, pix_sel);
        end
        tick();
        tick();
        n_vec++;
        if ({r, g, b} !== 24'h555555 || exp_rgb !== 24'h555555) begin
            n_err++;
            $display("FAIL mem_colour got %h model %h want 555555", {r, g, b}, exp_rgb);
        end
        for (int i = 0; i < 40; i++) begin
            video_x = 10'($urandom_range(0, 639));
            video_y = 10'($urandom_range(0, 479));
            pixel_in = 4'($urandom);
            tick();
            n_vec++;
            if ({r, g, b} !== exp_rgb || addr !== 9'(exp_addr) || pix_sel !== 3'(exp_sel)) begin
                n_err++;
                $display("FAIL addr_rand cyc %0d got rgb=%h addr=%0d sel=%0d want rgb=%h addr=%0d sel=%0d",
                         i, {r, g, b}, addr, pix_sel, exp_rgb, exp_addr, exp_sel);
            end
        end
    endtask

    task automatic test_border();
        video_x = 10'd600; video_y = 10'd100;
        for (int i = 0; i < 6; i++) begin
            pixel_in = 4'($urandom);
            tick();
            if (i >= 2) begin
                n_vec++;
                if ({r, g, b} !== 24'h111111 || exp_rgb !== 24'h111111) begin
                    n_err++;
                    $display("FAIL border_x600 cyc %0d got %h model %h want 111111", i, {r, g, b}, exp_rgb);
                end
            end
        end
        // Below the last row: cy = 48
        video_x = 10'd100; video_y = 10'd390;
        for (int i = 0; i < 3; i++) begin
            pixel_in = 4'($urandom);
            tick();
        end
        n_vec++;
        if ({r, g, b} !== 24'h111111) begin
            n_err++;
            $display("FAIL border_row48 got %h want 111111", {r, g, b});
        end
    endtask

    task automatic test_swap();
        int pulses = 0;
        swap_req = 1'b1; tick();
        swap_req = 1'b0; repeat (3) tick();
        swap_req = 1'b1; tick();
        swap_req = 1'b0; tick();
        n_vec++;
        if (bank !== 1'b0 || swap_done !== 1'b0) begin
            n_err++;
            $display("FAIL swap_early got bank=%b sd=%b want bank=0 sd=0", bank, swap_done);
        end
        frame_end = 1'b1; tick();
        frame_end = 1'b0;
        if (swap_done) pulses++;
        n_vec++;
        if (bank !== 1'b1 || bank !== m_bank) begin
            n_err++;
            $display("FAIL swap_flip got bank=%b want 1", bank);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (swap_done) pulses++;
        end
        frame_end = 1'b1; tick();
        frame_end = 1'b0;
        if (swap_done) pulses++;
        tick();
        if (swap_done) pulses++;
        n_vec++;
        if (pulses !== 1 || bank !== 1'b1) begin
            n_err++;
            $display("FAIL swap_once got pulses=%0d bank=%b want pulses=1 bank=1", pulses, bank);
        end
        swap_req = 1'b1; frame_end = 1'b1; tick();
        swap_req = 1'b0; frame_end = 1'b0;
        n_vec++;
        if (bank !== 1'b0 || swap_done !== 1'b1) begin
            n_err++;
            $display("FAIL swap_same_cycle got bank=%b sd=%b want bank=0 sd=1", bank, swap_done);
        end
    endtask

    task automatic test_mode_latch();
        mode = 2'd2; pixel_in = 4'h9; video_x = 10'd8; video_y = 10'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i >= 2) begin
                n_vec++;
                if ({r, g, b} !== 24'h999999) begin
                    n_err++;
                    $display("FAIL mode_hold cyc %0d got %h want 999999", i, {r, g, b});
                end
            end
        end
        frame_end = 1'b1; tick();
        frame_end = 1'b0;
        video_x = 10'd0; repeat (3) tick();
        n_vec++;
        if ({r, g, b} !== 24'h000000 || exp_rgb !== 24'h000000) begin
            n_err++;
            $display("FAIL checker_00 got %h model %h want 000000", {r, g, b}, exp_rgb);
        end
        video_x = 10'd8; repeat (3) tick();
        n_vec++;
        if ({r, g, b} !== 24'hFFFFFF || exp_rgb !== 24'hFFFFFF) begin
            n_err++;
            $display("FAIL checker_10 got %h model %h want FFFFFF", {r, g, b}, exp_rgb);
        end
    endtask

    task automatic test_palette();
        pal_we = 1'b1; pal_addr = 4'd7; pal_data = 24'hFF0000; tick();
        pal_we = 1'b0;
        mode = 2'd3; solid_idx = 4'd7; frame_end = 1'b1; tick();
        frame_end = 1'b0;
        repeat (3) tick();
        n_vec++;
        if ({r, g, b} !== 24'hFF0000 || exp_rgb !== 24'hFF0000) begin
            n_err++;
            $display("FAIL pal_solid7 got %h model %h want FF0000", {r, g, b}, exp_rgb);
        end
        display_enable = 1'b0; repeat (3) tick();
        n_vec++;
        if ({r, g, b} !== 24'h000000) begin
            n_err++;
            $display("FAIL blanking got %h want 000000", {r, g, b});
        end
        display_enable = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            video_x = 10'($urandom_range(0, 799));
            video_y = 10'($urandom_range(0, 524));
            display_enable = ($urandom_range(0, 7) != 0);
            frame_end = ($urandom_range(0, 15) == 0);
            mode = 2'($urandom);
            solid_idx = 4'($urandom);
            swap_req = ($urandom_range(0, 7) == 0);
            pal_we = ($urandom_range(0, 7) == 0);
            pal_addr = 4'($urandom);
            pal_data = 24'($urandom);
            pixel_in = 4'($urandom);
            tick();
            n_vec++;
            if ({r, g, b} !== exp_rgb || addr !== 9'(exp_addr) || pix_sel !== 3'(exp_sel) ||
                bank !== m_bank || swap_done !== m_sd || frame_cnt !== 8'(m_fc)) begin
                n_err++;
                $display("FAIL rand cyc %0d got rgb=%h addr=%0d sel=%0d bank=%b sd=%b fc=%0d want rgb=%h addr=%0d sel=%0d bank=%b sd=%b fc=%0d",
                         i, {r, g, b}, addr, pix_sel, bank, swap_done, frame_cnt,
                         exp_rgb, exp_addr, exp_sel, m_bank, m_sd, m_fc);
            end
        end
        frame_end = 1'b0; swap_req = 1'b0; pal_we = 1'b0; display_enable = 1'b1;
    endtask

    task automatic test_wrap();
        rst_n = 1'b0; #2; rst_n = 1'b1;
        m_reset();
        for (int i = 0; i < 255; i++) begin
            frame_end = 1'b1; tick();
            frame_end = 1'b0; tick();
        end
        n_vec++;
        if (frame_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL fc_255 got %0d want 255", frame_cnt);
        end
        mode = 2'd3; solid_idx = 4'hF; swap_req = 1'b1;
        frame_end = 1'b1; tick();
        frame_end = 1'b0; swap_req = 1'b0;
        n_vec++;
        if (frame_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL fc_wrap got %0d want 0", frame_cnt);
        end
        video_x = 10'd40; video_y = 10'd40;
        repeat (4) tick();
        n_vec++;
        if ({r, g, b} !== 24'hFFFFFF || bank !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset got rgb=%h bank=%b want FFFFFF bank=1", {r, g, b}, bank);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({r, g, b, addr, pix_sel, bank, swap_done, frame_cnt} !== '0) begin
            n_err++;
            $display("FAIL async_reset got rgb=%h addr=%0d sel=%0d bank=%b sd=%b fc=%0d want all 0",
                     {r, g, b}, addr, pix_sel, bank, swap_done, frame_cnt);
        end
        @(posedge clk_25); #1;
        rst_n = 1'b1;
        m_reset();
    endtask

    initial begin
        rst_n = 1'b0;
        video_x = '0; video_y = '0; display_enable = 1'b0; frame_end = 1'b0;
        mode = '0; solid_idx = '0; swap_req = 1'b0; pal_we = 1'b0;
        pal_addr = '0; pal_data = '0; pixel_in = '0;
        m_reset();
        #3;
        test_reset();
        test_addr_map();
        test_border();
        test_swap();
        test_mode_latch();
        test_palette();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gol_display_engine.md
# gol_display_engine

Parametrised pixel pipeline for the Game-of-Life VGA path. It maps each `video_x`/`video_y` to a scaled cell in a double-buffered cell memory. It selects a colour index from memory or one of three generated patterns, then resolves it through a writable 16-entry RGB palette. It sits between the VGA timing generator and the cell RAM, replacing the fixed counter/feeder/LUT path with a 3-cycle registered pipeline.

## Interface
Parameters:
- `CELL_SHIFT`, 3: cell size is 2^CELL_SHIFT × 2^CELL_SHIFT screen pixels.
- `COL_BITS`, 6: grid width is 2^COL_BITS cells (64).
- `ROWS`, 48: grid height in cells.
- `PPW_BITS`, 3: cells per memory word is 2^PPW_BITS (8); also the width of `pix_sel`.
- `ADDR_W`, 9: memory word address width. Must satisfy 2^ADDR_W·2^PPW_BITS ≥ ROWS·2^COL_BITS.
- `BORDER_IDX`, 4'h1: colour index used outside the grid.

Ports:
- `clk_25` in 1: pixel clock, single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `video_x`, `video_y` in 10 each: current beam position.
- `display_enable` in 1: beam is in the active area.
- `frame_end` in 1: one-cycle pulse at the end of each frame.
- `mode` in 2: requested source. 0 = memory, 1 = moving bars, 2 = checkerboard, 3 = solid.
- `solid_idx` in 4: colour index used in mode 3.
- `swap_req` in 1: pulse requesting a display-bank flip.
- `pal_we` in 1, `pal_addr` in 4, `pal_data` in 24 ({r,g,b}): palette write port.
- `pixel_in` in 4: cell value returned by memory.
- `bank` out 1: memory bank being displayed.
- `addr` out ADDR_W: memory word address.
- `pix_sel` out PPW_BITS: cell within the word.
- `swap_done` out 1: one-cycle pulse after a bank flip.
- `frame_cnt` out 8: count of frames since reset.
- `r`, `g`, `b` out 8 each: pixel colour.

## Operation
- Cell coordinates: `cx = video_x >> CELL_SHIFT`, `cy = video_y >> CELL_SHIFT`.
- The cell is in-grid when `cx < 2^COL_BITS` and `cy < ROWS`.
- Linear index `lin = {cy, cx[COL_BITS-1:0]}`. No multiplier.
- `addr = lin >> PPW_BITS`, truncated to ADDR_W. `pix_sel = lin[PPW_BITS-1:0]`.
- For out-of-grid cells, `addr`/`pix_sel` still update, and the selected index is forced to BORDER_IDX.
- Active mode register `mode_q` loads `mode` only in a cycle where `frame_end` = 1. No mid-frame tearing.
- Colour index selection by `mode_q`:
  - 0: `pixel_in`.
  - 1: `(frame_cnt[3:0] + cx[3:0])` mod 16.
  - 2: `cx[0]^cy[0]` ? 4'hF : 4'h0.
  - 3: `solid_idx`, sampled in stage 2.
- Bank swap:
  - `swap_req` sets sticky `swap_pend`.
  - On `frame_end` with `swap_pend` (or `swap_req`) high: `bank` toggles and `swap_pend` clears.
  - `swap_done` pulses high in the following cycle.
  - Multiple requests within one frame give exactly one flip.
- `frame_cnt` increments on every `frame_end` and wraps 255→0.
- Palette:
  - 16 × 24-bit registers. Reset value of entry i is r = g = b = i·17 (grey ramp, 0x00…0xFF).
  - `pal_we` writes `pal_data` to `pal_addr` at the clock edge.
  - Writes are allowed at any time; a mid-frame write is visible from the next pixel that reads that entry.
- Blanking: when the stage-2 copy of `display_enable` is 0, `r`/`g`/`b` register to 0.

## Timing
- Cycle T0: inputs sampled. `addr`, `pix_sel`, `cx`/`cy`, in-grid flag and `display_enable` registered.
- T1: `addr` valid at memory. The memory is synchronous: `pixel_in` is valid in T2. Stage 1 sideband is registered again.
- T2: index select and palette lookup, registered into `r`/`g`/`b`.
- T3: colour visible. Total latency is 3 cycles from `video_x`/`video_y` to RGB. The timing generator offsets sync by 3.
- A palette write at edge E affects a pixel whose stage 2 occurs after E.
- `mode` and `frame_end` in the same cycle: the new mode applies to the stage-0 pixel of the next cycle onward.
- `swap_req` and `frame_end` in the same cycle: the flip occurs at that `frame_end`.
- Reset values: `r`/`g`/`b`, `addr`, `pix_sel`, `bank`, `swap_done`, `frame_cnt`, `mode_q`, `swap_pend` are 0. Pipeline valid flags are cleared, so the outputs stay black for 3 cycles after release.
- Reset asserted mid-frame clears immediately (asynchronous). No partial swap survives.

## Test plan
- Mode 0 address mapping, defaults:
  - `video_x = 24`, `video_y = 8` → T1 shows `addr = 8`, `pix_sel = 3` (lin = 67).
  - With memory returning 4'h5 → T3 shows `r = g = b = 0x55`.
- Border: `video_x = 600` → T3 colour = palette[1] = 0x11 grey, regardless of `pixel_in`.
- Swap:
  - Two `swap_req` pulses mid-frame, then `frame_end` → `bank` goes 0→1 once, `swap_done` is high for exactly 1 cycle.
  - A following `frame_end` with no request → no flip.
- Mode latch:
  - `mode = 2` set mid-frame → output stays memory-sourced until `frame_end`.
  - Afterwards, cell (0,0) → 0x00 and cell (1,0) → 0xFF.
- Palette:
  - Write `pal_addr = 7`, `pal_data = 24'hFF0000`, then mode 3 with `solid_idx = 7` → `r = FF`, `g = 00`, `b = 00`.
  - `display_enable = 0` → all 0.
- Reset/wrap: 256 `frame_end` pulses → `frame_cnt` wraps to 0. Asserting `rst_n` low mid-frame → all outputs 0 in the same cycle.
